// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller.
package multicycle_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpSlti = 6'h0A;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpBne  = 6'h05;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;
    localparam logic [5:0] OpJ    = 6'h02;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluSlt   = 3'b011;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] SrcBRt    = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(logic [5:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OpR, OpAddi, OpSlti, OpBeq, OpBne, OpLw, OpSw, OpJ: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_ctrl_if;

    logic [5:0] instr_op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IorD_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic [1:0] PCSrc_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [2:0] ALU_op_o;
    logic       RegDst_o;
    logic       MemtoReg_o;
    logic       RegWrite_o;
    logic       illegal_o;

    modport master (
        input  instr_op_i, funct_i, zero_i, mem_ready_i,
        output mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o,
               ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegDst_o, MemtoReg_o, RegWrite_o, illegal_o
    );

    modport slave (
        output instr_op_i, funct_i, zero_i, mem_ready_i,
        input  mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o,
               ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegDst_o, MemtoReg_o, RegWrite_o, illegal_o
    );

endinterface

// File: rtl/multicycle_ctrl_out.sv
// Combinational decode of state, opcode and status flags into the control bundle.
module multicycle_ctrl_out
    import multicycle_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluAdd;
                ctrl_o.pc_src    = PcSrcAlu;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_b = SrcBImmSh;
                ctrl_o.alu_op    = AluAdd;
                ctrl_o.illegal   = ~op_legal(op_i);
            end
            StExec: begin
                case (op_i)
                    OpLw, OpSw: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBImm;
                        ctrl_o.alu_op    = AluAdd;
                    end
                    OpR: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBRt;
                        ctrl_o.alu_op    = AluFunct;
                    end
                    OpAddi: begin
                        ctrl_o.alu_src_b = SrcBImm;
                        ctrl_o.alu_op    = AluAdd;
                    end
                    OpSlti: begin
                        ctrl_o.alu_src_b = SrcBImm;
                        ctrl_o.alu_op    = AluSlt;
                    end
                    OpBeq, OpBne: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBRt;
                        ctrl_o.alu_op    = AluSub;
                        ctrl_o.pc_src    = PcSrcAluOut;
                        // Branch qualification happens here so the datapath needs no extra gate.
                        ctrl_o.pc_write  = (op_i == OpBeq) ? zero_i : ~zero_i;
                    end
                    OpJ: begin
                        ctrl_o.pc_src   = PcSrcJump;
                        ctrl_o.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_read  = (op_i == OpLw);
                ctrl_o.mem_write = (op_i == OpSw);
            end
            StWb: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = (op_i == OpR);
                ctrl_o.mem_to_reg = (op_i == OpLw);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: state register, sequencing and retired-instruction counter.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_ctrl_if.master bus,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [2:0]       state_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;
    ctrl_t             ctrl_raw, ctrl;
    logic              unused_funct;

    // funct is consumed by the ALU control, not by this FSM.
    assign unused_funct = ^bus.funct_i;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (bus.mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
                if (op_legal(bus.instr_op_i)) begin
                    state_d = StExec;
                end else begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExec: begin
                case (bus.instr_op_i)
                    OpLw, OpSw:          state_d = StMem;
                    OpR, OpAddi, OpSlti: state_d = StWb;
                    default: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                endcase
            end
            StMem: begin
                if (bus.mem_ready_i) begin
                    if (bus.instr_op_i == OpLw) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    multicycle_ctrl_out u_out (
        .state_i     (state_q),
        .op_i        (bus.instr_op_i),
        .zero_i      (bus.zero_i),
        .mem_ready_i (bus.mem_ready_i),
        .ctrl_o      (ctrl_raw)
    );

    // Reset blanks every control line immediately, not just from the next edge.
    assign ctrl = rst_i ? ctrl_raw : '0;

    assign bus.mem_req_o  = ctrl.mem_req;
    assign bus.MemRead_o  = ctrl.mem_read;
    assign bus.MemWrite_o = ctrl.mem_write;
    assign bus.IorD_o     = ctrl.iord;
    assign bus.IRWrite_o  = ctrl.ir_write;
    assign bus.PCWrite_o  = ctrl.pc_write;
    assign bus.PCSrc_o    = ctrl.pc_src;
    assign bus.ALUSrcA_o  = ctrl.alu_src_a;
    assign bus.ALUSrcB_o  = ctrl.alu_src_b;
    assign bus.ALU_op_o   = ctrl.alu_op;
    assign bus.RegDst_o   = ctrl.reg_dst;
    assign bus.MemtoReg_o = ctrl.mem_to_reg;
    assign bus.RegWrite_o = ctrl.reg_write;
    assign bus.illegal_o  = ctrl.illegal;

    assign instr_cnt_o = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (32-bit and 4-bit counter instances).
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    logic [2:0]  state;
    logic [2:0]  state4;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus4 ();

    multicycle_ctrl u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .instr_cnt_o (cnt32),
        .state_o     (state)
    );

    multicycle_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus4),
        .instr_cnt_o (cnt4),
        .state_o     (state4)
    );

    assign bus4.instr_op_i  = bus.instr_op_i;
    assign bus4.funct_i     = bus.funct_i;
    assign bus4.zero_i      = bus.zero_i;
    assign bus4.mem_ready_i = bus.mem_ready_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t act;
    always_comb begin
        act            = '0;
        act.mem_req    = bus.mem_req_o;
        act.mem_read   = bus.MemRead_o;
        act.mem_write  = bus.MemWrite_o;
        act.iord       = bus.IorD_o;
        act.ir_write   = bus.IRWrite_o;
        act.pc_write   = bus.PCWrite_o;
        act.pc_src     = bus.PCSrc_o;
        act.alu_src_a  = bus.ALUSrcA_o;
        act.alu_src_b  = bus.ALUSrcB_o;
        act.alu_op     = bus.ALU_op_o;
        act.reg_dst    = bus.RegDst_o;
        act.mem_to_reg = bus.MemtoReg_o;
        act.reg_write  = bus.RegWrite_o;
        act.illegal    = bus.illegal_o;
    end

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [2:0]  st;
        ctrl_t       exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   rdy_pat[10];
    int   st_pat[10];
    int   ir_cnt;
    int   req_gap;

    ctrl_t c_zero, c_fw, c_fr, c_dec, c_ill, c_exm, c_exr, c_exa, c_exs;
    ctrl_t c_bt, c_bn, c_j, c_mlw, c_msw, c_wr, c_wi, c_wl;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [2:0] st, input ctrl_t exp, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.exp = exp; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic rdy);
        rst             = r;
        bus.instr_op_i  = op;
        bus.funct_i     = 6'h20;
        bus.zero_i      = z;
        bus.mem_ready_i = rdy;
    endtask

    task automatic run_j();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 6'h02, 1'b0, 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 6'h00, 1'b0, 1'b1);

        c_zero = '0;
        c_fw = '0; c_fw.mem_req = 1'b1; c_fw.mem_read = 1'b1; c_fw.alu_src_b = 2'b01;
        c_fr = c_fw; c_fr.ir_write = 1'b1; c_fr.pc_write = 1'b1;
        c_dec = '0; c_dec.alu_src_b = 2'b11;
        c_ill = c_dec; c_ill.illegal = 1'b1;
        c_exm = '0; c_exm.alu_src_a = 1'b1; c_exm.alu_src_b = 2'b10;
        c_exr = '0; c_exr.alu_src_a = 1'b1; c_exr.alu_op = 3'b010;
        c_exa = '0; c_exa.alu_src_b = 2'b10;
        c_exs = c_exa; c_exs.alu_op = 3'b011;
        c_bt = '0; c_bt.alu_src_a = 1'b1; c_bt.alu_op = 3'b001; c_bt.pc_src = 2'b01;
        c_bt.pc_write = 1'b1;
        c_bn = c_bt; c_bn.pc_write = 1'b0;
        c_j = '0; c_j.pc_src = 2'b10; c_j.pc_write = 1'b1;
        c_mlw = '0; c_mlw.mem_req = 1'b1; c_mlw.iord = 1'b1; c_mlw.mem_read = 1'b1;
        c_msw = '0; c_msw.mem_req = 1'b1; c_msw.iord = 1'b1; c_msw.mem_write = 1'b1;
        c_wr = '0; c_wr.reg_write = 1'b1; c_wr.reg_dst = 1'b1;
        c_wi = '0; c_wi.reg_write = 1'b1;
        c_wl = '0; c_wl.reg_write = 1'b1; c_wl.mem_to_reg = 1'b1;

        // rst op zero rdy state expected cnt
        for (int i = 0; i < 3; i++) add(1'b0, 6'h00, 1'b0, 1'b1, 3'd0, c_zero, 0);
        add(1, 6'h00, 0, 1, 3'd0, c_fr, 0);   add(1, 6'h00, 0, 1, 3'd1, c_dec, 0);
        add(1, 6'h00, 0, 1, 3'd2, c_exr, 0);  add(1, 6'h00, 0, 1, 3'd4, c_wr, 0);
        add(1, 6'h08, 0, 1, 3'd0, c_fr, 1);   add(1, 6'h08, 0, 1, 3'd1, c_dec, 1);
        add(1, 6'h08, 0, 1, 3'd2, c_exa, 1);  add(1, 6'h08, 0, 1, 3'd4, c_wi, 1);
        add(1, 6'h0A, 0, 1, 3'd0, c_fr, 2);   add(1, 6'h0A, 0, 1, 3'd1, c_dec, 2);
        add(1, 6'h0A, 0, 1, 3'd2, c_exs, 2);  add(1, 6'h0A, 0, 1, 3'd4, c_wi, 2);
        add(1, 6'h2B, 0, 1, 3'd0, c_fr, 3);   add(1, 6'h2B, 0, 1, 3'd1, c_dec, 3);
        add(1, 6'h2B, 0, 1, 3'd2, c_exm, 3);  add(1, 6'h2B, 0, 1, 3'd3, c_msw, 3);
        add(1, 6'h04, 1, 1, 3'd0, c_fr, 4);   add(1, 6'h04, 1, 1, 3'd1, c_dec, 4);
        add(1, 6'h04, 1, 1, 3'd2, c_bt, 4);
        add(1, 6'h04, 0, 1, 3'd0, c_fr, 5);   add(1, 6'h04, 0, 1, 3'd1, c_dec, 5);
        add(1, 6'h04, 0, 1, 3'd2, c_bn, 5);
        add(1, 6'h05, 0, 1, 3'd0, c_fr, 6);   add(1, 6'h05, 0, 1, 3'd1, c_dec, 6);
        add(1, 6'h05, 0, 1, 3'd2, c_bt, 6);
        add(1, 6'h05, 1, 1, 3'd0, c_fr, 7);   add(1, 6'h05, 1, 1, 3'd1, c_dec, 7);
        add(1, 6'h05, 1, 1, 3'd2, c_bn, 7);
        add(1, 6'h3F, 0, 1, 3'd0, c_fr, 8);   add(1, 6'h3F, 0, 1, 3'd1, c_ill, 8);
        add(1, 6'h02, 0, 0, 3'd0, c_fw, 9);   add(1, 6'h02, 0, 1, 3'd0, c_fr, 9);
        add(1, 6'h02, 0, 0, 3'd1, c_dec, 9);  add(1, 6'h02, 0, 0, 3'd2, c_j, 9);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d ctrl", i), 32'(act), 32'(vecs[i].exp));
            chk($sformatf("vec%0d cnt", i), cnt32, vecs[i].cnt);
            chk($sformatf("vec%0d cnt4", i), 32'(cnt4), 32'(vecs[i].cnt[3:0]));
        end

        // lw: two fetch wait cycles, three memory wait cycles
        rdy_pat = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        st_pat  = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        ir_cnt  = 0;
        req_gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 6'h23, 1'b0, rdy_pat[i] != 0);
            #1;
            chk($sformatf("lw cyc%0d state", i), 32'(state), 32'(st_pat[i]));
            if ((st_pat[i] == 0 || st_pat[i] == 3) && !bus.mem_req_o) req_gap++;
            if (bus.IRWrite_o) ir_cnt++;
            if (i >= 5 && i <= 8) chk($sformatf("lw mem%0d ctrl", i), 32'(act), 32'(c_mlw));
            if (i == 9) chk("lw wb ctrl", 32'(act), 32'(c_wl));
        end
        chk("lw req gaps", 32'(req_gap), 32'd0);
        chk("lw irwrite cycles", 32'(ir_cnt), 32'd1);
        @(negedge clk);
        drive(1'b1, 6'h2B, 1'b0, 1'b1);
        #1;
        chk("lw done state", 32'(state), 32'd0);
        chk("lw done cnt", cnt32, 32'd11);

        // sw stalled in MEM, then reset
        @(negedge clk); drive(1'b1, 6'h2B, 1'b0, 1'b1);
        @(negedge clk); drive(1'b1, 6'h2B, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 6'h2B, 1'b0, 1'b0);
            #1;
            chk($sformatf("sw stall%0d ctrl", i), 32'(act), 32'(c_msw));
        end
        @(negedge clk);
        drive(1'b0, 6'h2B, 1'b0, 1'b0);
        #1;
        chk("rst mem ctrl", 32'(act), 32'(c_zero));
        @(negedge clk);
        drive(1'b0, 6'h2B, 1'b0, 1'b1);
        #1;
        chk("rst state", 32'(state), 32'd0);
        chk("rst cnt", cnt32, 32'd0);
        chk("rst memwrite", 32'(bus.MemWrite_o), 32'd0);

        // 17 jumps from reset: the 4-bit counter wraps to 1
        @(negedge clk);
        drive(1'b1, 6'h02, 1'b0, 1'b1);
        #1;
        chk("restart state", 32'(state), 32'd0);
        chk("restart ctrl", 32'(act), 32'(c_fr));
        @(negedge clk); drive(1'b1, 6'h02, 1'b0, 1'b1);
        @(negedge clk); drive(1'b1, 6'h02, 1'b0, 1'b1);
        #1;
        chk("j exec ctrl", 32'(act), 32'(c_j));
        @(posedge clk);
        #1;
        chk("j1 cnt", cnt32, 32'd1);
        for (int n = 2; n <= 17; n++) begin
            run_j();
            if (n == 15) chk("cnt4 at 15", 32'(cnt4), 32'd15);
            if (n == 16) chk("cnt4 at 16", 32'(cnt4), 32'd0);
            if (n == 17) chk("cnt4 at 17", 32'(cnt4), 32'd1);
        end
        chk("cnt32 at 17", cnt32, 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
